// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_slave
// Brief    : AHB-Lite SRAM slave with wait states, burst checking, two-cycle
//            ERROR response and write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [1:0]            htrans,
  input  logic                  hmastlock,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BOFS   = $clog2(NBYTES);
  localparam int WIDX   = $clog2(MEM_DEPTH);
  localparam int TOPB   = WIDX + BOFS;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              wcnt_q, wcnt_d;
  logic [TOPB-1:0]         addr_q, addr_d;
  logic                    write_q, write_d;
  logic [2:0]              size_q, size_d;
  logic [2:0]              burst_q, burst_d;
  logic [4:0]              beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   exp_addr_q, exp_addr_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    accept, is_seq, range_err, size_err, align_err, seq_err, xfer_err;
  logic [4:0]              len_q;
  logic [7:0]              amask;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic                    commit, load_rd;
  logic [WIDX-1:0]         wr_idx, rd_idx;
  logic [NBYTES-1:0]       be;
  logic [DATA_WIDTH-1:0]   fwd_word;
  logic                    unused_ok;

  assign unused_ok = ^{hprot, hmastlock};

  function automatic logic [4:0] burst_len(input logic [2:0] bt);
    case (bt[2:1])
      2'b01:   burst_len = 5'd4;
      2'b10:   burst_len = 5'd8;
      2'b11:   burst_len = 5'd16;
      default: burst_len = 5'd0;
    endcase
  endfunction

  // Next beat address; WRAPn keeps the upper bits of an n*2^size aligned block
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] sz,
                                                      input logic [2:0] bt);
    logic [ADDR_WIDTH-1:0] inc, msk, sum;
    inc = ADDR_WIDTH'(1) << sz;
    msk = (ADDR_WIDTH'(burst_len(bt)) << sz) - ADDR_WIDTH'(1);
    sum = a + inc;
    if ((bt[2:1] != 2'b00) && !bt[0])
      next_addr = (a & ~msk) | (sum & msk);
    else
      next_addr = sum;
  endfunction

  generate
    if (ADDR_WIDTH > TOPB) begin : g_range
      assign range_err = |haddr[ADDR_WIDTH-1:TOPB];
    end else begin : g_no_range
      assign range_err = 1'b0;
    end
  endgenerate

  assign accept    = hsel && hready && htrans[1];
  assign is_seq    = (htrans == 2'b11);
  assign size_err  = (hsize > 3'(BOFS));
  assign amask     = (8'd1 << hsize) - 8'd1;
  assign align_err = |(haddr[2:0] & amask[2:0]);
  assign len_q     = burst_len(burst_q);
  assign seq_err   = is_seq && ((haddr != exp_addr_q) ||
                                ((len_q != 5'd0) && (beat_q >= len_q)));
  assign xfer_err  = range_err || size_err || align_err || seq_err;
  assign nxt_addr  = next_addr(haddr, hsize, hburst);

  assign commit = hresetn && (state_q == S_DATA) && write_q && hready;
  assign wr_idx = addr_q[TOPB-1:BOFS];
  assign rd_idx = (state_q == S_WAIT) ? addr_q[TOPB-1:BOFS] : haddr[TOPB-1:BOFS];

  always_comb begin
    be = '0;
    for (int b = 0; b < NBYTES; b++)
      if ((b >> size_q) == (int'(addr_q[BOFS-1:0]) >> size_q)) be[b] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    exp_addr_d = exp_addr_q;
    load_rd    = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (wcnt_q <= 2'd1) begin
          state_d = S_DATA;
          load_rd = !write_q;
        end else begin
          wcnt_d = wcnt_q - 2'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (hready) begin
          if (accept) begin
            addr_d  = haddr[TOPB-1:0];
            write_d = hwrite;
            size_d  = hsize;
            burst_d = hburst;
            if (!is_seq) begin
              beat_d     = 5'd1;
              exp_addr_d = nxt_addr;
            end else if (!xfer_err) begin
              beat_d     = (beat_q == 5'h1f) ? beat_q : beat_q + 5'd1;
              exp_addr_d = nxt_addr;
            end
            if (xfer_err) begin
              state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              wcnt_d  = 2'(WAIT_STATES);
            end else begin
              state_d = S_DATA;
              load_rd = !hwrite;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  // A write committing on the same edge must be visible to the read being loaded
  always_comb begin
    fwd_word = mem_q[rd_idx];
    if (commit && (wr_idx == rd_idx))
      for (int b = 0; b < NBYTES; b++)
        if (be[b]) fwd_word[8*b +: 8] = hwdata[8*b +: 8];
    hrdata_d = load_rd ? fwd_word : hrdata_q;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      exp_addr_q <= '0;
      hrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      exp_addr_q <= exp_addr_d;
      hrdata_q   <= hrdata_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (commit)
      for (int b = 0; b < NBYTES; b++)
        if (be[b]) mem_q[wr_idx][8*b +: 8] <= hwdata[8*b +: 8];
  end

  assign hreadyout = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign hrdata    = hrdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sram_slave
// Brief    : Scoreboard bench for ahb_sram_slave, zero- and two-wait instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2, B_INCR4 = 3'd3;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel0 = 1'b0, hsel1 = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = '0;
  logic [3:0]  hprot = 4'h3;
  logic [1:0]  htrans = T_IDLE;
  logic        hmastlock = 1'b0;
  logic [31:0] hwdata = '0;
  logic        hreadyout0, hresp0, hreadyout1, hresp1;
  logic [31:0] hrdata0, hrdata1;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock),
    .hready(hreadyout0), .hwdata(hwdata), .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0));

  ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock),
    .hready(hreadyout1), .hwdata(hwdata), .hreadyout(hreadyout1), .hresp(hresp1), .hrdata(hrdata1));

  typedef struct packed {
    logic [31:0] id;
    logic        k;
    logic        resp;
    logic [1:0]  waits;
    logic [31:0] rdata;
    logic        chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   next_id = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: tracks data phases per DUT from bus activity and scores each completion
  bit dp[2];
  int wc[2];
  bit lo0[2], lo1[2];
  always @(negedge hclk) begin : mon
    logic rdy, rsp, sel;
    logic [31:0] rd;
    exp_t e;
    if (!hresetn) begin
      for (int k = 0; k < 2; k++) begin
        dp[k] = 1'b0; wc[k] = 0; lo0[k] = 1'b0; lo1[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        rdy = (k == 1) ? hreadyout1 : hreadyout0;
        rsp = (k == 1) ? hresp1 : hresp0;
        rd  = (k == 1) ? hrdata1 : hrdata0;
        sel = (k == 1) ? hsel1 : hsel0;
        if (dp[k]) begin
          if (!rdy) begin
            wc[k]++;
            if (rsp) lo1[k] = 1'b1; else lo0[k] = 1'b1;
          end else begin
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_resp dut%0d: resp=%0b with empty scoreboard", k, rsp);
            end else begin
              e = exp_q.pop_front();
              if ((int'(e.k) != k) || (rsp !== e.resp) || (wc[k] != int'(e.waits)) ||
                  (e.resp ? lo0[k] : lo1[k]) || (e.chk && (rd !== e.rdata))) begin
                n_fail++;
                $display("FAIL xfer%0d dut%0d: resp=%0b waits=%0d rdata=%h lo0=%0b lo1=%0b, required dut%0d resp=%0b waits=%0d rdata=%h",
                         e.id, k, rsp, wc[k], rd, lo0[k], lo1[k], e.k, e.resp, e.waits,
                         e.chk ? e.rdata : rd);
              end
            end
          end
        end
        if (rdy) begin
          dp[k] = sel && htrans[1];
          wc[k] = 0; lo0[k] = 1'b0; lo1[k] = 1'b0;
        end
      end
    end
  end

  // Drives one address phase, waits for acceptance, then drives its write data
  task automatic issue(input int k, input bit en, input logic [1:0] tr, input bit wr,
                       input logic [31:0] a, input logic [2:0] sz, input logic [2:0] bt,
                       input logic [31:0] wd, input bit er, input logic [31:0] rd);
    exp_t e;
    logic rdy;
    int   n;
    hsel0 = en && (k == 0); hsel1 = en && (k == 1);
    htrans = tr; hwrite = wr; haddr = a; hsize = sz; hburst = bt;
    if (en && tr[1]) begin
      e.id = next_id; e.k = 1'(k); e.resp = er;
      e.waits = er ? 2'd1 : ((k == 1) ? 2'd2 : 2'd0);
      e.rdata = rd; e.chk = !wr && !er;
      exp_q.push_back(e);
      next_id++;
    end
    n = 0;
    do begin
      @(negedge hclk);
      rdy = (k == 1) ? hreadyout1 : hreadyout0;
      @(posedge hclk); #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout dut%0d addr=%h: hready stayed 0, required 1", k, a);
    end
    hwdata = wd;
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = T_IDLE;
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input bit er = 0);
    issue(k, 1, T_NS, 1, a, 3'd2, B_SINGLE, d, er, '0);
  endtask

  task automatic rd(input int k, input logic [31:0] a, input logic [31:0] d);
    issue(k, 1, T_NS, 0, a, 3'd2, B_SINGLE, '0, 0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge hclk); #1;
    end
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    idle(3);
    check("rst_hreadyout0", 32'(hreadyout0), 32'd1);
    check("rst_hresp0",     32'(hresp0),     32'd0);
    check("rst_hrdata0",    hrdata0,         32'd0);
    check("rst_hreadyout1", 32'(hreadyout1), 32'd1);
    check("rst_hresp1",     32'(hresp1),     32'd0);
    check("rst_hrdata1",    hrdata1,         32'd0);
    hresetn = 1'b1;
    idle(1);

    // single write/read, read forwarded from the committing write
    wr(0, 32'h0, 32'h64);
    rd(0, 32'h0, 32'h64);
    wr(0, 32'h4, 32'h11223344);
    issue(0, 1, T_NS, 1, 32'h5, 3'd0, B_SINGLE, 32'h0000AA00, 0, '0);
    rd(0, 32'h4, 32'h1122AA44);

    // WRAP4 burst 0x8, 0xC, 0x0, 0x4
    issue(0, 1, T_NS,  1, 32'h8, 3'd2, B_WRAP4, 32'd1, 0, '0);
    issue(0, 1, T_SEQ, 1, 32'hC, 3'd2, B_WRAP4, 32'd2, 0, '0);
    issue(0, 1, T_SEQ, 1, 32'h0, 3'd2, B_WRAP4, 32'd3, 0, '0);
    issue(0, 1, T_SEQ, 1, 32'h4, 3'd2, B_WRAP4, 32'd4, 0, '0);
    rd(0, 32'h0, 32'd3);
    rd(0, 32'h4, 32'd4);
    rd(0, 32'h8, 32'd1);
    rd(0, 32'hC, 32'd2);

    // no side effects from deselected, IDLE and BUSY cycles
    issue(0, 0, T_NS,   1, 32'h0, 3'd2, B_SINGLE, 32'hDEAD, 0, '0);
    issue(0, 1, T_IDLE, 1, 32'h0, 3'd2, B_SINGLE, 32'hDEAD, 0, '0);
    issue(0, 1, T_BUSY, 1, 32'h0, 3'd2, B_SINGLE, 32'hDEAD, 0, '0);
    rd(0, 32'h0, 32'd3);

    // address, size and alignment errors leave memory untouched
    wr(0, 32'h400, 32'hBAD, 1);
    wr(0, 32'h2, 32'hFFFFFFFF, 1);
    issue(0, 1, T_NS, 1, 32'h1, 3'd1, B_SINGLE, 32'hFFFFFFFF, 1, '0);
    issue(0, 1, T_NS, 0, 32'h0, 3'd3, B_SINGLE, '0, 1, '0);
    rd(0, 32'h0, 32'd3);

    // SEQ address mismatch and SEQ past the end of INCR4
    wr(0, 32'h20, 32'h77);
    wr(0, 32'h40, 32'h88);
    issue(0, 1, T_NS,  1, 32'h10, 3'd2, B_INCR, 32'h50, 0, '0);
    issue(0, 1, T_SEQ, 1, 32'h20, 3'd2, B_INCR, 32'h52, 1, '0);
    rd(0, 32'h20, 32'h77);
    rd(0, 32'h10, 32'h50);
    for (int i = 0; i < 4; i++)
      issue(0, 1, (i == 0) ? T_NS : T_SEQ, 1, 32'h30 + 32'(4*i), 3'd2, B_INCR4, 32'h30 + 32'(i), 0, '0);
    issue(0, 1, T_SEQ, 1, 32'h40, 3'd2, B_INCR4, 32'hEE, 1, '0);
    rd(0, 32'h40, 32'h88);
    rd(0, 32'h3C, 32'h33);

    // halfword lane write, then hrdata must hold across a write data phase
    wr(0, 32'h44, 32'h99);
    issue(0, 1, T_NS, 1, 32'h46, 3'd1, B_SINGLE, 32'h12340000, 0, '0);
    rd(0, 32'h44, 32'h12340099);
    wr(0, 32'h48, 32'h5);
    idle(4);
    @(negedge hclk);
    check("hrdata_hold", hrdata0, 32'h12340099);
    @(posedge hclk); #1;

    // two-wait-state instance
    wr(1, 32'h8, 32'hCAFE);
    rd(1, 32'h8, 32'hCAFE);
    rd(1, 32'h400, '0);
    exp_q[exp_q.size()-1].resp = 1'b1;
    exp_q[exp_q.size()-1].waits = 2'd1;
    exp_q[exp_q.size()-1].chk = 1'b0;
    rd(1, 32'h8, 32'hCAFE);
    idle(5);

    // reset during the WAIT state of a write aborts it
    issue(1, 1, T_NS, 1, 32'h8, 3'd2, B_SINGLE, 32'hBEEF, 0, '0);
    @(negedge hclk);
    check("wait_hreadyout_low", 32'(hreadyout1), 32'd0);
    #2 hresetn = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_hreadyout", 32'(hreadyout1), 32'd1);
    check("rst_mid_hresp",     32'(hresp1),     32'd0);
    check("rst_mid_hrdata",    hrdata1,         32'd0);
    idle(2);
    hresetn = 1'b1;
    idle(1);
    rd(1, 32'h8, 32'hCAFE);
    idle(6);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
